spi_cs_controller: RTL and testbench
====================================

// Module: spi_cs_controller
// PURPOSE
//  Transaction layer directly upstream of the SPI byte master. Owns chip select and splits a
//  multi-byte transaction into single-byte hand-offs to the byte master. Returns each received
//  byte to the host, tagged with its index. Holds CS_n low across all bytes of a transaction and
//  enforces a minimum CS_n-high gap between transactions.
// PARAMETERS
//  MAX_BYTES_PER_CS   2   max bytes per transaction; sets count widths W=$clog2(MAX_BYTES_PER_CS+1)
//  CS_INACTIVE_CLKS   1   i_clk cycles CS_n held high after a transaction before the next starts (>=1)
// PORTS
//  i_clk         in   1  system clock, all logic rising-edge
//  i_rst_n       in   1  asynchronous active-low reset
//  i_TX_Count    in   W  bytes in transaction; sampled with first i_TX_DV only
//  i_TX_Byte     in   8  host byte to send
//  i_TX_DV       in   1  one-cycle strobe: i_TX_Byte (and, on first byte, i_TX_Count) valid
//  o_TX_Ready    out  1  host may assert i_TX_DV this cycle
//  o_RX_Count    out  W  index (0-based) of byte on o_RX_Byte
//  o_RX_DV       out  1  one-cycle strobe: o_RX_Byte/o_RX_Count valid
//  o_RX_Byte     out  8  received byte
//  o_M_TX_Byte   out  8  byte to byte master
//  o_M_TX_DV     out  1  one-cycle start strobe to byte master
//  i_M_TX_Ready  in   1  byte master idle
//  i_M_RX_DV     in   1  byte master finished a byte
//  i_M_RX_Byte   in   8  byte master received byte
//  o_SPI_CS_n    out  1  chip select, active low
// BEHAVIOUR
//  Reset values: o_SPI_CS_n=1, o_TX_Ready=0, o_RX_DV=0, o_RX_Byte=0, o_RX_Count=0,
//   o_M_TX_DV=0, o_M_TX_Byte=0, state=IDLE, byte counters=0. Reset mid-transaction aborts at once.
//   CS_n rises asynchronously with reset. No pending byte survives reset.
//  FSM states: IDLE, TRANSFER, CS_INACTIVE.
//  IDLE:
//   - o_SPI_CS_n=1.
//   - o_TX_Ready=1 iff i_M_TX_Ready=1.
//   - On i_TX_DV&o_TX_Ready with i_TX_Count!=0:
//     - latch count, clamped to MAX_BYTES_PER_CS;
//     - next edge: o_SPI_CS_n<=0, o_M_TX_Byte<=i_TX_Byte, o_M_TX_DV<=1 for one cycle;
//     - tx_left<=count-1, rx_idx<=0; go TRANSFER.
//   - i_TX_DV with i_TX_Count==0 is ignored and stays in IDLE.
//  TRANSFER:
//   - busy flag set on each o_M_TX_DV, cleared on i_M_RX_DV. i_M_TX_Ready is ignored while busy
//     (the byte master still reports ready on the cycle it samples DV).
//   - o_TX_Ready=1 iff !busy & !o_M_TX_DV & i_M_TX_Ready & tx_left!=0.
//   - i_TX_DV while ready: forward byte registered, exactly as in IDLE; tx_left-=1. CS_n stays low.
//   - Every i_M_RX_DV: next edge o_RX_DV<=1, o_RX_Byte<=i_M_RX_Byte, o_RX_Count<=rx_idx;
//     then rx_idx+=1.
//   - After the last byte's i_M_RX_DV (tx_left==0, not busy): o_SPI_CS_n<=1 on the same edge that
//     issues o_RX_DV; go CS_INACTIVE.
//   - Host starving (no i_TX_DV while ready): CS_n stays low indefinitely; there is no timeout.
//  CS_INACTIVE:
//   - CS_n=1, o_TX_Ready=0.
//   - Counts CS_INACTIVE_CLKS cycles, then IDLE.
//  Ignored inputs:
//   - i_TX_DV while o_TX_Ready=0 is dropped: no output change, no counter change.
//   - i_M_RX_DV while in IDLE or CS_INACTIVE is dropped.
//  Latency:
//   - Host DV -> o_M_TX_DV: 1 cycle.
//   - i_M_RX_DV -> o_RX_DV: 1 cycle.
//   - CS_n falls on the same edge as the first o_M_TX_DV.
//  Counters wrap never: rx_idx max = MAX_BYTES_PER_CS-1.
// STRUCTURE
//  Single module, no sub-module. FSM state encodings and the W width function go in the shared
//  spi_pkg package, alongside the SPI mode constants.
// TESTING (byte master model or real byte master, MODE 0, CLKS_PER_HALF_BIT=3, MISO looped to MOSI)
//  1 Reset idle: i_rst_n=0 -> CS_n=1, all strobes 0; release -> o_TX_Ready=1 within 2 clks.
//  2 Single byte: Count=1, Byte=8'hA5 -> one o_M_TX_DV, CS_n low, one o_RX_DV with 8'hA5,
//    o_RX_Count=0, CS_n high on the same edge.
//  3 Two bytes: Count=2, 8'h3C then 8'hC3 -> CS_n low continuously, RX (0,3C),(1,C3), then
//    CS_n high >=CS_INACTIVE_CLKS.
//  4 Back-to-back: two Count=1 transactions, i_TX_DV held pending -> second DV accepted only
//    after CS_INACTIVE gap.
//  5 Illegal requests: Count=0 -> no activity; i_TX_DV with o_TX_Ready=0 -> dropped;
//    Count=3 -> clamped to 2 bytes.
//  6 Reset mid-transaction: i_rst_n low during first byte of Count=2 -> CS_n=1 immediately,
//    no o_RX_DV, clean restart.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI types, mode constants and count-width helper
package spi_pkg;

    // SPI clock polarity/phase modes {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE_0 = 2'b00;
    localparam logic [1:0] SPI_MODE_1 = 2'b01;
    localparam logic [1:0] SPI_MODE_2 = 2'b10;
    localparam logic [1:0] SPI_MODE_3 = 2'b11;

    // Chip-select transaction states
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_TRANSFER    = 2'd1,
        ST_CS_INACTIVE = 2'd2
    } cs_state_e;

    // Bits needed to hold values 0..max_count inclusive (never less than one)
    function automatic int count_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/spi_cs_controller.sv
// rtl/spi_cs_controller.sv - chip-select owner splitting transactions into byte hand-offs
module spi_cs_controller
    import spi_pkg::*;
#(
    parameter int MAX_BYTES_PER_CS = 2,
    parameter int CS_INACTIVE_CLKS = 1,
    localparam int W = count_width(MAX_BYTES_PER_CS)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_TX_Count,
    input  logic [7:0]   i_TX_Byte,
    input  logic         i_TX_DV,
    output logic         o_TX_Ready,
    output logic [W-1:0] o_RX_Count,
    output logic         o_RX_DV,
    output logic [7:0]   o_RX_Byte,
    output logic [7:0]   o_M_TX_Byte,
    output logic         o_M_TX_DV,
    input  logic         i_M_TX_Ready,
    input  logic         i_M_RX_DV,
    input  logic [7:0]   i_M_RX_Byte,
    output logic         o_SPI_CS_n
);

    localparam int             GW       = count_width(CS_INACTIVE_CLKS);
    localparam logic [W-1:0]   MAX_CNT  = W'(MAX_BYTES_PER_CS);
    localparam logic [GW-1:0]  GAP_LAST = GW'(CS_INACTIVE_CLKS - 1);

    cs_state_e     state_q, state_d;
    logic [W-1:0]  tx_left_q, tx_left_d;
    logic [W-1:0]  rx_idx_q, rx_idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          busy_q, busy_d;
    logic          ready_en_q, ready_en_d;
    logic          cs_n_q, cs_n_d;
    logic          m_tx_dv_q, m_tx_dv_d;
    logic [7:0]    m_tx_byte_q, m_tx_byte_d;
    logic          rx_dv_q, rx_dv_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic [W-1:0]  rx_count_q, rx_count_d;
    logic          tx_ready;
    logic [W-1:0]  count_eff;

    // Next-state, handshake and output-register logic for the transaction FSM
    always_comb begin
        state_d     = state_q;
        tx_left_d   = tx_left_q;
        rx_idx_d    = rx_idx_q;
        gap_d       = gap_q;
        busy_d      = busy_q;
        ready_en_d  = 1'b1;
        cs_n_d      = cs_n_q;
        m_tx_dv_d   = 1'b0;
        m_tx_byte_d = m_tx_byte_q;
        rx_dv_d     = 1'b0;
        rx_byte_d   = rx_byte_q;
        rx_count_d  = rx_count_q;
        tx_ready    = 1'b0;
        count_eff   = (i_TX_Count > MAX_CNT) ? MAX_CNT : i_TX_Count;

        case (state_q)
            ST_IDLE: begin
                cs_n_d   = 1'b1;
                // ready_en_q keeps the host handshake low for the first cycle out of reset
                tx_ready = ready_en_q & i_M_TX_Ready;
                if (i_TX_DV && tx_ready && (i_TX_Count != '0)) begin
                    cs_n_d      = 1'b0;
                    m_tx_byte_d = i_TX_Byte;
                    m_tx_dv_d   = 1'b1;
                    busy_d      = 1'b1;
                    tx_left_d   = count_eff - 1'b1;
                    rx_idx_d    = '0;
                    state_d     = ST_TRANSFER;
                end
            end

            ST_TRANSFER: begin
                // The byte master still reports ready on the cycle it samples DV,
                // so our own busy/strobe flags gate the handshake instead.
                tx_ready = !busy_q && !m_tx_dv_q && i_M_TX_Ready && (tx_left_q != '0);
                if (i_TX_DV && tx_ready) begin
                    m_tx_byte_d = i_TX_Byte;
                    m_tx_dv_d   = 1'b1;
                    busy_d      = 1'b1;
                    tx_left_d   = tx_left_q - 1'b1;
                end
                if (i_M_RX_DV) begin
                    busy_d     = 1'b0;
                    rx_dv_d    = 1'b1;
                    rx_byte_d  = i_M_RX_Byte;
                    rx_count_d = rx_idx_q;
                    if (tx_left_q == '0) begin
                        // Last byte returned: release CS on the same edge as its RX strobe
                        cs_n_d  = 1'b1;
                        gap_d   = '0;
                        state_d = ST_CS_INACTIVE;
                    end else begin
                        rx_idx_d = rx_idx_q + 1'b1;
                    end
                end
            end

            ST_CS_INACTIVE: begin
                cs_n_d = 1'b1;
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            default: begin
                cs_n_d  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction and raises CS at once
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            tx_left_q   <= '0;
            rx_idx_q    <= '0;
            gap_q       <= '0;
            busy_q      <= 1'b0;
            ready_en_q  <= 1'b0;
            cs_n_q      <= 1'b1;
            m_tx_dv_q   <= 1'b0;
            m_tx_byte_q <= 8'h00;
            rx_dv_q     <= 1'b0;
            rx_byte_q   <= 8'h00;
            rx_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            tx_left_q   <= tx_left_d;
            rx_idx_q    <= rx_idx_d;
            gap_q       <= gap_d;
            busy_q      <= busy_d;
            ready_en_q  <= ready_en_d;
            cs_n_q      <= cs_n_d;
            m_tx_dv_q   <= m_tx_dv_d;
            m_tx_byte_q <= m_tx_byte_d;
            rx_dv_q     <= rx_dv_d;
            rx_byte_q   <= rx_byte_d;
            rx_count_q  <= rx_count_d;
        end
    end

    assign o_TX_Ready  = tx_ready;
    assign o_RX_Count  = rx_count_q;
    assign o_RX_DV     = rx_dv_q;
    assign o_RX_Byte   = rx_byte_q;
    assign o_M_TX_Byte = m_tx_byte_q;
    assign o_M_TX_DV   = m_tx_dv_q;
    assign o_SPI_CS_n  = cs_n_q;

endmodule

// File: tb/tb_spi_cs_controller.sv
// tb/tb_spi_cs_controller.sv - scoreboard bench for spi_cs_controller with looped-back byte master
module tb_spi_cs_controller;

    localparam int MAXB      = 2;
    localparam int CS_GAP    = 1;
    localparam int BYTE_CLKS = 8 * 2 * 3;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] tx_count;
    logic [7:0] tx_byte;
    logic       tx_dv;
    logic       tx_ready;
    logic [1:0] rx_count;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic [7:0] m_tx_byte;
    logic       m_tx_dv;
    logic       m_tx_ready;
    logic       m_rx_dv;
    logic [7:0] m_rx_byte;
    logic       cs_n;

    logic       inject_rx;
    logic       mb_busy;
    logic [7:0] mb_byte;
    int         mb_cnt;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   m_dv_count = 0;
    int   rx_seen = 0;
    int   cs_falls = 0;
    int   hi_run = 0;
    int   last_gap = 0;
    bit   prev_cs = 1'b1;
    int   base_dv, base_rx, base_falls;

    always #5 clk = ~clk;

    spi_cs_controller #(
        .MAX_BYTES_PER_CS(MAXB),
        .CS_INACTIVE_CLKS(CS_GAP)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_TX_Count  (tx_count),
        .i_TX_Byte   (tx_byte),
        .i_TX_DV     (tx_dv),
        .o_TX_Ready  (tx_ready),
        .o_RX_Count  (rx_count),
        .o_RX_DV     (rx_dv),
        .o_RX_Byte   (rx_byte),
        .o_M_TX_Byte (m_tx_byte),
        .o_M_TX_DV   (m_tx_dv),
        .i_M_TX_Ready(m_tx_ready),
        .i_M_RX_DV   (m_rx_dv),
        .i_M_RX_Byte (m_rx_byte),
        .o_SPI_CS_n  (cs_n)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Byte master model: MISO looped to MOSI, so each byte returns unchanged after one byte time
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mb_busy    <= 1'b0;
            mb_byte    <= 8'h00;
            mb_cnt     <= 0;
            m_tx_ready <= 1'b1;
            m_rx_dv    <= 1'b0;
            m_rx_byte  <= 8'h00;
        end else begin
            m_rx_dv <= 1'b0;
            if (inject_rx) begin
                m_rx_dv   <= 1'b1;
                m_rx_byte <= 8'h99;
            end
            if (!mb_busy && m_tx_dv) begin
                mb_busy    <= 1'b1;
                m_tx_ready <= 1'b0;
                mb_byte    <= m_tx_byte;
                mb_cnt     <= BYTE_CLKS;
            end else if (mb_busy) begin
                if (mb_cnt == 1) begin
                    mb_busy    <= 1'b0;
                    m_tx_ready <= 1'b1;
                    m_rx_dv    <= 1'b1;
                    m_rx_byte  <= mb_byte;
                end else begin
                    mb_cnt <= mb_cnt - 1;
                end
            end
        end
    end

    // Output monitor: scoreboard pops on RX strobes, CS activity bookkeeping
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_dv) begin
                rx_seen++;
                if (exp_q.size() == 0) begin
                    check_eq("rx_unexpected", 32'(rx_dv), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("rx_byte", 32'(rx_byte), 32'(mon_e.data));
                    check_eq("rx_count", 32'(rx_count), 32'(mon_e.idx));
                    if (mon_e.last) check_eq("cs_rise_with_last_rx", 32'(cs_n), 32'd1);
                    else            check_eq("cs_low_mid_txn", 32'(cs_n), 32'd0);
                end
            end
            if (m_tx_dv) begin
                m_dv_count++;
                check_eq("cs_low_at_m_tx_dv", 32'(cs_n), 32'd0);
            end
            if (cs_n) begin
                hi_run++;
            end else begin
                if (prev_cs) begin
                    cs_falls++;
                    last_gap = hi_run;
                end
                hi_run = 0;
            end
            prev_cs = cs_n;
        end else begin
            prev_cs = 1'b1;
            hi_run  = 0;
        end
    end

    task automatic send_byte(input logic [1:0] cnt, input logic [7:0] b,
                             input logic [1:0] idx, input bit last);
        int waited = 0;
        while (!tx_ready && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (!tx_ready) begin
            check_eq("tx_ready_timeout", 32'(tx_ready), 32'd1);
            return;
        end
        tx_dv    = 1'b1;
        tx_count = cnt;
        tx_byte  = b;
        exp_q.push_back(exp_t'{idx: idx, data: b, last: last});
        @(negedge clk);
        tx_dv = 1'b0;
        check_eq("m_tx_dv_latency", 32'(m_tx_dv), 32'd1);
        check_eq("m_tx_byte", 32'(m_tx_byte), 32'(b));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic mark();
        base_dv    = m_dv_count;
        base_rx    = rx_seen;
        base_falls = cs_falls;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int waited;
        rst_n     = 1'b0;
        tx_dv     = 1'b0;
        tx_count  = 2'd0;
        tx_byte   = 8'h00;
        inject_rx = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_cs_n", 32'(cs_n), 32'd1);
        check_eq("rst_tx_ready", 32'(tx_ready), 32'd0);
        check_eq("rst_m_tx_dv", 32'(m_tx_dv), 32'd0);
        check_eq("rst_rx_dv", 32'(rx_dv), 32'd0);
        check_eq("rst_rx_byte", 32'(rx_byte), 32'd0);
        check_eq("rst_rx_count", 32'(rx_count), 32'd0);
        check_eq("rst_m_tx_byte", 32'(m_tx_byte), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("ready_after_reset", 32'(tx_ready), 32'd1);

        // Single byte
        mark();
        send_byte(2'd1, 8'hA5, 2'd0, 1'b1);
        drain();
        check_eq("single_m_dv_count", 32'(m_dv_count - base_dv), 32'd1);
        check_eq("single_cs_falls", 32'(cs_falls - base_falls), 32'd1);

        // Two bytes under one CS
        mark();
        send_byte(2'd2, 8'h3C, 2'd0, 1'b0);
        send_byte(2'd2, 8'hC3, 2'd1, 1'b1);
        drain();
        check_eq("two_m_dv_count", 32'(m_dv_count - base_dv), 32'd2);
        check_eq("two_cs_falls", 32'(cs_falls - base_falls), 32'd1);
        repeat (CS_GAP) @(negedge clk);
        check_eq("two_cs_high_after", 32'(hi_run >= CS_GAP), 32'd1);

        // Back-to-back with the next request held pending
        mark();
        send_byte(2'd1, 8'h11, 2'd0, 1'b1);
        tx_dv    = 1'b1;
        tx_count = 2'd1;
        tx_byte  = 8'h5A;
        waited   = 0;
        while (!tx_ready && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (!tx_ready) begin
            check_eq("b2b_ready_timeout", 32'(tx_ready), 32'd1);
        end else begin
            exp_q.push_back(exp_t'{idx: 2'd0, data: 8'h5A, last: 1'b1});
        end
        @(negedge clk);
        tx_dv = 1'b0;
        check_eq("b2b_second_m_dv", 32'(m_tx_dv), 32'd1);
        drain();
        check_eq("b2b_m_dv_count", 32'(m_dv_count - base_dv), 32'd2);
        check_eq("b2b_cs_gap", 32'(last_gap >= CS_GAP + 1), 32'd1);

        // Count of zero is ignored
        mark();
        waited = 0;
        while (!tx_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        tx_dv    = 1'b1;
        tx_count = 2'd0;
        tx_byte  = 8'hFF;
        @(negedge clk);
        tx_dv = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("cnt0_m_dv_count", 32'(m_dv_count - base_dv), 32'd0);
        check_eq("cnt0_cs_n", 32'(cs_n), 32'd1);
        check_eq("cnt0_rx_count", 32'(rx_seen - base_rx), 32'd0);

        // Host strobe while not ready is dropped
        mark();
        send_byte(2'd2, 8'h21, 2'd0, 1'b0);
        repeat (5) @(negedge clk);
        check_eq("busy_tx_ready", 32'(tx_ready), 32'd0);
        tx_dv    = 1'b1;
        tx_count = 2'd2;
        tx_byte  = 8'hEE;
        @(negedge clk);
        tx_dv = 1'b0;
        send_byte(2'd2, 8'h42, 2'd1, 1'b1);
        drain();
        check_eq("drop_m_dv_count", 32'(m_dv_count - base_dv), 32'd2);

        // Count above the maximum clamps to two bytes
        mark();
        send_byte(2'd3, 8'h77, 2'd0, 1'b0);
        send_byte(2'd3, 8'h88, 2'd1, 1'b1);
        repeat (3) @(negedge clk);
        check_eq("clamp_no_third_ready", 32'(tx_ready), 32'd0);
        drain();
        check_eq("clamp_m_dv_count", 32'(m_dv_count - base_dv), 32'd2);
        check_eq("clamp_cs_n_end", 32'(cs_n), 32'd1);

        // Byte-master strobe while idle is dropped
        mark();
        repeat (4) @(negedge clk);
        inject_rx = 1'b1;
        @(negedge clk);
        inject_rx = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("idle_rx_dropped", 32'(rx_seen - base_rx), 32'd0);

        // Reset in the middle of the first byte of a two-byte transaction
        send_byte(2'd2, 8'h5C, 2'd0, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_cs_n", 32'(cs_n), 32'd1);
        check_eq("midrst_rx_dv", 32'(rx_dv), 32'd0);
        check_eq("midrst_m_tx_dv", 32'(m_tx_dv), 32'd0);
        check_eq("midrst_tx_ready", 32'(tx_ready), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mark();
        repeat (2) @(negedge clk);
        send_byte(2'd1, 8'hE7, 2'd0, 1'b1);
        drain();
        repeat (BYTE_CLKS + 10) @(negedge clk);
        check_eq("restart_rx_count", 32'(rx_seen - base_rx), 32'd1);
        check_eq("restart_m_dv_count", 32'(m_dv_count - base_dv), 32'd1);
        check_eq("restart_cs_n", 32'(cs_n), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
